// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key-schedule datapaths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int         NUM_ROUNDS = 10;
  // Rcon used to step back from the round-10 key to the round-9 key.
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;
  typedef logic [3:0]   round_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    CALC
  } state_t;

  // Inverse of xtime on the Rcon sequence: halve, except 1B, which came
  // from 80 via the polynomial reduction.
  function automatic byte_t inv_rcon(input byte_t rc);
    return (rc == 8'h1B) ? 8'h80 : (rc >> 1);
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the inverse key schedule and its key consumer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls key emission; in_ready gates start.
// Ports: start/key_in load side, key_out/round_out/rcon_out/out_valid/out_ready/last key side.
interface aes_inv_key_sched_if;
  import aes_pkg::*;

  logic   start;
  key_t   key_in;
  logic   in_ready;
  key_t   key_out;
  round_t round_out;
  byte_t  rcon_out;
  logic   out_valid;
  logic   out_ready;
  logic   last;

  // master: the block that loads keys and consumes round keys.
  modport master (
    output start, key_in, out_ready,
    input  in_ready, key_out, round_out, rcon_out, out_valid, last
  );

  // slave: the key schedule engine.
  modport slave (
    input  start, key_in, out_ready,
    output in_ready, key_out, round_out, rcon_out, out_valid, last
  );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational lookup.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: data (byte in), sub (substituted byte out).
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t data,
  output byte_t sub
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[data];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key expansion: loads the round-10 key, emits rounds 10..0.
// Latency: first key 1 cycle after load, then one key every 2 cycles (EMIT/CALC).
// Backpressure: out_ready=0 holds EMIT with all outputs stable; start only taken when in_ready.
// Ports: clock, reset (sync, active-high), bus (slave side of aes_inv_key_sched_if).
module aes_inv_key_sched
  import aes_pkg::*;
(
  input logic                clock,
  input logic                reset,
  aes_inv_key_sched_if.slave bus
);

  state_t state;
  state_t state_nxt;

  key_t   key_q;
  round_t round_q;
  byte_t  rcon_q;

  // ---------------------------------------------------------------------------
  // Backward key step: recover the previous round key from the current one.
  // ---------------------------------------------------------------------------
  word_t w0, w1, w2, w3;
  word_t p0, p1, p2, p3;
  word_t rot;
  word_t sub;
  key_t  key_nxt;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Undo the forward chain w[i] = w[i-1] ^ w[i-4] for the three plain words.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // p3 is the last word of the previous key, so it feeds the g() function.
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot[8*i +: 8]),
      .sub  (sub[8*i +: 8])
    );
  end

  assign p0      = w0 ^ sub ^ {rcon_q, 24'h000000};
  assign key_nxt = {p0, p1, p2, p3};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_nxt = (round_q == '0) ? IDLE : CALC;
        end
      end
      CALC: begin
        state_nxt = EMIT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.last      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.last      = (round_q == '0);
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Key / round / rcon registers; only move on load or in CALC, so a stalled
  // EMIT keeps them bit-stable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_q   <= bus.key_in;
            round_q <= round_t'(NUM_ROUNDS);
            rcon_q  <= RCON_LAST;
          end
        end
        CALC: begin
          key_q   <= key_nxt;
          round_q <= round_q - round_t'(1);
          rcon_q  <= inv_rcon(rcon_q);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.key_out   = key_q;
  assign bus.round_out = round_q;
  assign bus.rcon_out  = rcon_q;

endmodule
